// File: rtl/miriscv_arb_pkg.sv
// Shared types for the two-master data port arbiter: FSM states and owner encoding.
package miriscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick: on a tie the master that did not win last time is chosen.
module rr_arbiter_2
  import miriscv_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_last,
  output owner_t     o_sel,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    if (i_req == 2'b11) begin
      o_sel = ~i_last;
    end else if (i_req[1]) begin
      o_sel = OWNER_M1;
    end else begin
      o_sel = OWNER_M0;
    end
  end

endmodule

// File: rtl/data_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid data port between two masters, one transaction in flight.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module data_port_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,

  output logic        busy_o
);

  arb_state_t r_state;
  owner_t     r_owner;
  owner_t     r_last;
  logic       r_we;

  owner_t      w_sel;
  logic        w_valid;
  owner_t      w_cur;
  logic        w_active;
  logic        w_grant;
  logic        w_wait;
  logic        w_timeout;
  logic        w_resp;
  logic        w_err;
  logic        w_cur_we;
  logic [31:0] w_rdata;

  rr_arbiter_2 u_rr (
    .i_req   ({m1_req_i, m0_req_i}),
    .i_last  (r_last),
    .o_sel   (w_sel),
    .o_valid (w_valid)
  );

  // Owner is the live pick only while idle; once latched it stays frozen until the response.
  assign w_cur    = (r_state == IDLE) ? w_sel : r_owner;
  assign w_active = ((r_state == IDLE) && w_valid) || (r_state == REQ);
  assign w_grant  = w_active && s_gnt_i;
  assign w_cur_we = (w_cur == OWNER_M1) ? m1_we_i : m0_we_i;

  assign s_req_o   = w_active;
  assign s_we_o    = w_active && w_cur_we;
  assign s_be_o    = !w_active ? 4'd0  : (w_cur == OWNER_M1) ? m1_be_i    : m0_be_i;
  assign s_addr_o  = !w_active ? 32'd0 : (w_cur == OWNER_M1) ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o = !w_active ? 32'd0 : (w_cur == OWNER_M1) ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o = w_grant && (w_cur == OWNER_M0);
  assign m1_gnt_o = w_grant && (w_cur == OWNER_M1);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_grant) begin
      r_cnt <= '0;
    end else if (w_wait && !s_rvalid_i && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // A real response on the timeout cycle wins; err only fires when the slave stayed silent.
  assign w_wait  = (r_state == WAIT);
  assign w_resp  = w_wait && (s_rvalid_i || w_timeout);
  assign w_err   = w_wait && w_timeout && !s_rvalid_i;
  assign w_rdata = (w_wait && s_rvalid_i && !r_we) ? s_rdata_i : 32'd0;

  assign m0_rvalid_o = w_resp && (r_owner == OWNER_M0);
  assign m1_rvalid_o = w_resp && (r_owner == OWNER_M1);
  assign m0_rdata_o  = (r_owner == OWNER_M0) ? w_rdata : 32'd0;
  assign m1_rdata_o  = (r_owner == OWNER_M1) ? w_rdata : 32'd0;
  assign m0_err_o    = w_err && (r_owner == OWNER_M0);
  assign m1_err_o    = w_err && (r_owner == OWNER_M1);

  assign busy_o = (r_state != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_owner <= OWNER_M0;
      r_last  <= OWNER_M1;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner <= w_sel;
            r_we    <= w_cur_we;
            if (s_gnt_i) begin
              r_last  <= w_sel;
              r_state <= WAIT;
            end else begin
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (s_gnt_i) begin
            r_last  <= r_owner;
            r_we    <= w_cur_we;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed self-checking bench for data_port_arbiter; covers the ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_data_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        m0_req_i, m0_we_i;
  logic [3:0]  m0_be_i;
  logic [31:0] m0_addr_i, m0_wdata_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i, m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_addr_i, m1_wdata_i;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_rdata_o;
  logic        s_req_o, s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic        s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        busy_o;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk_i = ~clk_i;

  data_port_arbiter #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .m0_req_i    (m0_req_i),
    .m0_we_i     (m0_we_i),
    .m0_be_i     (m0_be_i),
    .m0_addr_i   (m0_addr_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m0_err_o    (m0_err_o),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_be_i     (m1_be_i),
    .m1_addr_i   (m1_addr_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .m1_err_o    (m1_err_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_be_o      (s_be_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_gnt_i     (s_gnt_i),
    .s_rvalid_i  (s_rvalid_i),
    .s_rdata_i   (s_rdata_i),
    .busy_o      (busy_o)
  );

  task automatic applyStimulus(input logic req0, input logic we0, input logic [31:0] addr0,
                               input logic req1, input logic we1, input logic [31:0] addr1,
                               input logic gnt, input logic rvalid, input logic [31:0] rdata);
    m0_req_i   = req0;
    m0_we_i    = we0;
    m0_be_i    = 4'hF;
    m0_addr_i  = addr0;
    m0_wdata_i = addr0 ^ 32'hA5A5_0000;
    m1_req_i   = req1;
    m1_we_i    = we1;
    m1_be_i    = 4'b0011;
    m1_addr_i  = addr1;
    m1_wdata_i = 32'hCAFE_0001;
    s_gnt_i    = gnt;
    s_rvalid_i = rvalid;
    s_rdata_i  = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_i = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick;
    tick;
    #3;
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_sreq", 32'(s_req_o), 32'd0);
    checkOutput("reset_saddr", s_addr_o, 32'd0);
    checkOutput("reset_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
    checkOutput("reset_rvalid", {28'd0, m1_err_o, m0_err_o, m1_rvalid_o, m0_rvalid_o}, 32'd0);
    checkOutput("reset_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    rst_n_i = 1'b1;
    tick;

    // Stray rvalid in IDLE with no requests
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h1234_5678);
    #3;
    checkOutput("stray_rvalid", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
    checkOutput("stray_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    checkOutput("stray_busy", 32'(busy_o), 32'd0);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    #3;
    checkOutput("stray_idle_after", 32'(busy_o), 32'd0);
    tick;

    // Lone read from m0
    applyStimulus(1, 0, 32'h10, 0, 0, 32'h0, 1, 0, 32'h0);
    #3;
    checkOutput("lone_sreq", 32'(s_req_o), 32'd1);
    checkOutput("lone_saddr", s_addr_o, 32'h10);
    checkOutput("lone_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd1);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    #3;
    checkOutput("lone_rvalid", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd1);
    checkOutput("lone_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    checkOutput("lone_m1_rdata", m1_rdata_o, 32'd0);
    checkOutput("lone_err", {30'd0, m1_err_o, m0_err_o}, 32'd0);
    checkOutput("lone_wait_nogrant", {29'd0, s_req_o, m1_gnt_o, m0_gnt_o}, 32'd0);
    checkOutput("lone_busy", 32'(busy_o), 32'd1);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    #3;
    checkOutput("lone_back_idle", 32'(busy_o), 32'd0);

    // Continuous contention after a fresh reset: grants alternate m0, m1, m0, m1
    rst_n_i = 1'b0;
    #1;
    rst_n_i = 1'b1;
    tick;
    applyStimulus(1, 0, 32'h100, 1, 0, 32'h200, 1, 1, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      #3;
      checkOutput($sformatf("rr_gnt%0d", i), {30'd0, m1_gnt_o, m0_gnt_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput($sformatf("rr_addr%0d", i), s_addr_o, (i % 2 == 0) ? 32'h100 : 32'h200);
      tick;
      #3;
      checkOutput($sformatf("rr_rvalid%0d", i), {28'd0, m1_rvalid_o, m0_rvalid_o, m1_gnt_o, m0_gnt_o},
                  (i % 2 == 0) ? 32'd4 : 32'd8);
      tick;
    end

    // Slave stall on an m1 write; m0 arrives mid-stall but must wait
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h8000_0000, 0, 0, 32'h0);
    #3;
    checkOutput("stall_addr0", s_addr_o, 32'h8000_0000);
    checkOutput("stall_be", {27'd0, s_we_o, s_be_o}, 32'h13);
    checkOutput("stall_wdata", s_wdata_o, 32'hCAFE_0001);
    tick;
    applyStimulus(1, 0, 32'h44, 1, 1, 32'h8000_0000, 0, 0, 32'h0);
    for (int i = 1; i < 3; i++) begin
      #3;
      checkOutput($sformatf("stall_addr%0d", i), s_addr_o, 32'h8000_0000);
      checkOutput($sformatf("stall_nogrant%0d", i), {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
      tick;
    end
    applyStimulus(1, 0, 32'h44, 1, 1, 32'h8000_0000, 1, 0, 32'h0);
    #3;
    checkOutput("stall_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd2);
    checkOutput("stall_addr_gnt", s_addr_o, 32'h8000_0000);
    tick;
    applyStimulus(1, 0, 32'h44, 0, 0, 32'h0, 0, 1, 32'h55AA_55AA);
    #3;
    checkOutput("stall_wr_ack", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd2);
    checkOutput("stall_wr_rdata", m1_rdata_o, 32'd0);
    tick;
    applyStimulus(1, 0, 32'h44, 0, 0, 32'h0, 1, 0, 32'h0);
    #3;
    checkOutput("stall_m0_next", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd1);
    checkOutput("stall_m0_addr", s_addr_o, 32'h44);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0102_0304);
    #3;
    checkOutput("stall_m0_rdata", m0_rdata_o, 32'h0102_0304);
    tick;

    // Reset while WAIT: response dropped, last owner forgotten
    applyStimulus(1, 0, 32'h300, 1, 0, 32'h400, 1, 0, 32'h0);
    #3;
    checkOutput("rst_pre_gnt", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd2);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    checkOutput("rst_pre_busy", 32'(busy_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    rst_n_i = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h7777_7777);
    #1;
    checkOutput("rst_no_rvalid", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
    tick;
    applyStimulus(1, 0, 32'h300, 1, 0, 32'h400, 1, 0, 32'h0);
    #3;
    checkOutput("rst_tie_m0", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd1);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0000_0300);
    #3;
    checkOutput("rst_post_rvalid", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd1);
    tick;

`ifdef ARB_TIMEOUT_EN
    // Unanswered m0 read: watchdog fires once the counter reaches 4
    applyStimulus(1, 0, 32'h20, 0, 0, 32'h0, 1, 0, 32'h0);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      #3;
      checkOutput($sformatf("to_quiet%0d", i), {30'd0, m0_err_o, m0_rvalid_o}, 32'd0);
      tick;
    end
    #3;
    checkOutput("to_fire", {29'd0, m1_rvalid_o, m0_err_o, m0_rvalid_o}, 32'd3);
    checkOutput("to_rdata", m0_rdata_o, 32'd0);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'hBEEF_0000);
    #3;
    checkOutput("to_late_ignored", {28'd0, m0_err_o, m0_rvalid_o, busy_o, m1_rvalid_o}, 32'd0);
    tick;
`else
    // Without the watchdog an unanswered read just holds WAIT
    applyStimulus(1, 0, 32'h20, 0, 0, 32'h0, 1, 0, 32'h0);
    tick;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    repeat (10) tick;
    #3;
    checkOutput("hold_wait", {29'd0, busy_o, m0_err_o, m0_rvalid_o}, 32'd4);
    tick;
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
